// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory load/store unit: Funct3 codes, FSM
// states and the store lane/alignment helper.
package dm_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } dm_state_e;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
        logic        misaligned;
    } dm_lanes_t;

    // Access size comes from Funct3 so the same helper flags misaligned loads.
    function automatic dm_lanes_t dm_store_lanes(input logic [2:0]  funct3,
                                                 input logic [1:0]  a_lo,
                                                 input logic [31:0] wd);
        dm_lanes_t l;
        l.be         = 4'b0000;
        l.data       = 32'h0;
        l.misaligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                l.be   = 4'b0001 << a_lo;
                l.data = {4{wd[7:0]}};
            end
            F3_H, F3_HU: begin
                l.be         = a_lo[1] ? 4'b1100 : 4'b0011;
                l.data       = {2{wd[15:0]}};
                l.misaligned = a_lo[0];
            end
            F3_W: begin
                l.be         = 4'b1111;
                l.data       = wd;
                l.misaligned = |a_lo;
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/dm_lsu_bytebank.sv
// Single-port word RAM built from four byte-wide lanes, each with its own
// write enable; a written lane returns the new byte on the same access.
module dm_bytebank #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rdata_q;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we[gi]) begin
                        mem[addr] <= wdata[8*gi +: 8];
                        rdata_q   <= wdata[8*gi +: 8];
                    end else begin
                        rdata_q   <= mem[addr];
                    end
                end
            end

            assign rdata[8*gi +: 8] = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/dm_lsu.sv
// Registered, handshaked load/store unit: request decode, byte-lane stores,
// extended loads and a response register that holds under back-pressure.
module dm_lsu
    import dm_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    input  logic [2:0]            Funct3,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     rd,
    output logic                  err
);

    localparam int AW    = DM_ADDRESS - 2;
    localparam int DEPTH = 2 ** AW;

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("dm_lsu: DATA_W must be 32");
        end
    endgenerate

    dm_state_e   state_q, state_d;
    logic [1:0]  a_lo_q, a_lo_d;
    logic [2:0]  f3_q, f3_d;
    logic        err_q, err_d;
    logic        load_q, load_d;

    logic        accept;
    logic        is_load, is_store, legal_f3, fault;
    logic        ram_en;
    logic [3:0]  ram_we;
    dm_lanes_t   lanes;
    logic [31:0] ram_rdata;
    logic [31:0] load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        is_load  = MemRead && !MemWrite;
        is_store = MemWrite && !MemRead;
        legal_f3 = 1'b0;
        if (is_load) begin
            legal_f3 = (Funct3 == F3_B) || (Funct3 == F3_H) || (Funct3 == F3_W) ||
                       (Funct3 == F3_BU) || (Funct3 == F3_HU);
        end else if (is_store) begin
            legal_f3 = (Funct3 == F3_B) || (Funct3 == F3_H) || (Funct3 == F3_W);
        end
        lanes = dm_store_lanes(Funct3, a[1:0], wd);
        fault = !legal_f3 || lanes.misaligned;
        // Reset gates the RAM so nothing is written while reset_n is low.
        ram_en = accept && !fault && reset_n;
        ram_we = is_store ? lanes.be : 4'b0000;
    end

    dm_bytebank #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bank (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (a[DM_ADDRESS-1:2]),
        .wdata (lanes.data),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b1;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                req_ready  = resp_ready;
                if (resp_ready && !req_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        accept = req_valid && req_ready;
    end

    always_comb begin
        a_lo_d = a_lo_q;
        f3_d   = f3_q;
        err_d  = err_q;
        load_d = load_q;
        if (accept) begin
            a_lo_d = a[1:0];
            f3_d   = Funct3;
            err_d  = fault;
            load_d = is_load && !fault;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_lo_q  <= 2'b00;
            f3_q    <= 3'b000;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_lo_q  <= a_lo_d;
            f3_q    <= f3_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        byte_sel = ram_rdata[8*a_lo_q +: 8];
        half_sel = a_lo_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (f3_q)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = ram_rdata;
        endcase
    end

    assign rd  = (resp_valid && load_q) ? load_data : '0;
    assign err = resp_valid && err_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu: expected responses are queued when a request is
// driven and compared when the response appears.
module tb_dm_lsu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready;
    logic        MemRead, MemWrite;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [2:0]  Funct3;
    logic        resp_valid, resp_ready;
    logic [31:0] rd;
    logic        err;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    dm_lsu #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .a          (a),
        .wd         (wd),
        .Funct3     (Funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .rd         (rd),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [8:0] addr, input logic [31:0] data,
                         input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        req_valid = 1'b1;
        MemRead   = mr;
        MemWrite  = mw;
        Funct3    = f3;
        a         = addr;
        wd        = data;
        e.rd      = exp_rd;
        e.err     = exp_err;
        exp_q.push_back(e);
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
    endtask

    task automatic check_resp(input string tag);
        exp_t e;
        chk({tag, ".valid"}, {31'h0, resp_valid}, 32'h1);
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 32'h0, 32'h1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".rd"}, rd, e.rd);
            chk({tag, ".err"}, {31'h0, err}, {31'h0, e.err});
        end
        $display("txn %s: rd=%h err=%0b", tag, rd, err);
    endtask

    // One request from IDLE, response checked one cycle after the accept edge.
    task automatic txn(input string tag, input logic mr, input logic mw, input logic [2:0] f3,
                       input logic [8:0] addr, input logic [31:0] data,
                       input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        chk({tag, ".pre_valid"}, {31'h0, resp_valid}, 32'h0);
        chk({tag, ".pre_ready"}, {31'h0, req_ready}, 32'h1);
        drive(mr, mw, f3, addr, data, exp_rd, exp_err);
        @(posedge clk);
        #1 idle_req();
        @(negedge clk);
        check_resp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t dropped;
        reset_n    = 1'b0;
        resp_ready = 1'b1;
        a          = '0;
        wd         = '0;
        Funct3     = '0;
        idle_req();

        #3;
        chk("reset.resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("reset.req_ready", {31'h0, req_ready}, 32'h1);
        chk("reset.rd", rd, 32'h0);
        chk("reset.err", {31'h0, err}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        txn("sw_010", 1'b0, 1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0);
        txn("lw_010", 1'b1, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0);
        txn("sw_020", 1'b0, 1'b1, 3'b010, 9'h020, 32'h11223344, 32'h0, 1'b0);
        txn("sb_021", 1'b0, 1'b1, 3'b000, 9'h021, 32'h000000F0, 32'h0, 1'b0);
        txn("lw_020", 1'b1, 1'b0, 3'b010, 9'h020, 32'h0, 32'h1122F044, 1'b0);
        txn("lb_021", 1'b1, 1'b0, 3'b000, 9'h021, 32'h0, 32'hFFFFFFF0, 1'b0);
        txn("lbu_021", 1'b1, 1'b0, 3'b100, 9'h021, 32'h0, 32'h000000F0, 1'b0);
        txn("lb_023", 1'b1, 1'b0, 3'b000, 9'h023, 32'h0, 32'h00000011, 1'b0);
        txn("lh_020", 1'b1, 1'b0, 3'b001, 9'h020, 32'h0, 32'hFFFFF044, 1'b0);
        txn("lhu_022", 1'b1, 1'b0, 3'b101, 9'h022, 32'h0, 32'h00001122, 1'b0);
        txn("sw_030", 1'b0, 1'b1, 3'b010, 9'h030, 32'h0, 32'h0, 1'b0);
        txn("sh_032", 1'b0, 1'b1, 3'b001, 9'h032, 32'h00008001, 32'h0, 1'b0);
        txn("lh_032", 1'b1, 1'b0, 3'b001, 9'h032, 32'h0, 32'hFFFF8001, 1'b0);
        txn("lhu_032", 1'b1, 1'b0, 3'b101, 9'h032, 32'h0, 32'h00008001, 1'b0);
        txn("lw_030", 1'b1, 1'b0, 3'b010, 9'h030, 32'h0, 32'h80010000, 1'b0);

        // Faulting requests: no RAM access, err=1, rd=0.
        txn("sh_033_mis", 1'b0, 1'b1, 3'b001, 9'h033, 32'h00001234, 32'h0, 1'b1);
        txn("lw_012_mis", 1'b1, 1'b0, 3'b010, 9'h012, 32'h0, 32'h0, 1'b1);
        txn("ld_f3_011", 1'b1, 1'b0, 3'b011, 9'h010, 32'h0, 32'h0, 1'b1);
        txn("st_f3_100", 1'b0, 1'b1, 3'b100, 9'h010, 32'h0, 32'h0, 1'b1);
        txn("rd_and_wr", 1'b1, 1'b1, 3'b010, 9'h030, 32'h0, 32'h0, 1'b1);
        txn("neither", 1'b0, 1'b0, 3'b010, 9'h030, 32'h0, 32'h0, 1'b1);
        txn("lw_030_kept", 1'b1, 1'b0, 3'b010, 9'h030, 32'h0, 32'h80010000, 1'b0);
        txn("lw_010_kept", 1'b1, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0);

        // Back-to-back stream: store, byte store, load of the same word.
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b010, 9'h050, 32'h12345678, 32'h0, 1'b0);
        @(posedge clk);
        #1 drive(1'b0, 1'b1, 3'b000, 9'h053, 32'h000000AB, 32'h0, 1'b0);
        @(negedge clk);
        check_resp("b2b_sw_050");
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 3'b010, 9'h050, 32'h0, 32'hAB345678, 1'b0);
        @(negedge clk);
        check_resp("b2b_sb_053");
        @(posedge clk);
        #1 idle_req();
        @(negedge clk);
        check_resp("b2b_lw_050");

        // Back-pressure: response held for three cycles with a request queued.
        @(negedge clk);
        resp_ready = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 3'b100, 9'h021, 32'h0, 32'h000000F0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall.resp_valid", {31'h0, resp_valid}, 32'h1);
            chk("stall.req_ready", {31'h0, req_ready}, 32'h0);
            chk("stall.rd", rd, exp_q[0].rd);
            chk("stall.err", {31'h0, err}, {31'h0, exp_q[0].err});
        end
        dropped = exp_q.pop_front();
        $display("txn stall_lw_010: rd=%h err=%0b", rd, err);
        resp_ready = 1'b1;
        #1 chk("release.req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 idle_req();
        @(negedge clk);
        check_resp("queued_lbu_021");

        // Reset while a store response is pending.
        @(negedge clk);
        drive(1'b0, 1'b1, 3'b010, 9'h040, 32'hCAFEF00D, 32'h0, 1'b0);
        @(posedge clk);
        #1 idle_req();
        resp_ready = 1'b0;
        chk("pre_reset.resp_valid", {31'h0, resp_valid}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset.resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("async_reset.rd", rd, 32'h0);
        chk("async_reset.err", {31'h0, err}, 32'h0);
        chk("async_reset.req_ready", {31'h0, req_ready}, 32'h1);
        dropped = exp_q.pop_front();
        $display("txn reset_drop: resp_valid=%0b rd=%h", resp_valid, rd);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        MemWrite   = 1'b1;
        Funct3     = 3'b010;
        a          = 9'h010;
        wd         = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_req();
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset.resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("post_reset.req_ready", {31'h0, req_ready}, 32'h1);

        txn("lw_040_kept", 1'b1, 1'b0, 3'b010, 9'h040, 32'h0, 32'hCAFEF00D, 1'b0);
        txn("lw_010_no_rst_wr", 1'b1, 1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0);

        chk("queue_empty", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dm_lsu.md
# dm_lsu

Parametrised, handshaked data memory for the RISC-V core. It replaces the combinational load/store path with a registered request/response unit. The unit has true byte-lane writes for SB/SH/SW and sign- or zero-extended loads for LB/LH/LW/LBU/LHU. It detects misaligned and illegal accesses, and it holds its response under back-pressure. It sits between the execute stage (ALU address, rs2 data, Funct3, MemRead/MemWrite) and write-back.

## Interface
- DM_ADDRESS, 9: byte-address width; depth = 2**(DM_ADDRESS-2) words.
- DATA_W, 32: data width. Only 32 is legal; an elaboration-time assertion rejects any other value.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- MemRead  in  1  load request (from control unit).
- MemWrite  in  1  store request (from control unit).
- a  in  DM_ADDRESS  byte address (ALU output LSBs).
- wd  in  DATA_W  store data (rs2).
- Funct3  in  3  instruction bits 14:12.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- rd  out  DATA_W  load result, already extended; 0 for stores and errors.
- err  out  1  access faulted (misaligned, illegal Funct3, or MemRead&&MemWrite).

## Operation
- Accept = req_valid && req_ready. Inputs are sampled only on accept.
- Load Funct3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Any other value is illegal.
- Store Funct3 values: 000 SB, 001 SH, 010 SW. Any other value is illegal.
- Alignment rules:
  - halfword ops need a[0]==0;
  - word ops need a[1:0]==00;
  - byte ops are always aligned.
- Faulting request (misaligned, illegal, both or neither of MemRead/MemWrite): no RAM read or write; response carries err=1, rd=0.
- Store byte enables:
  - SB: 1 lane, a[1:0];
  - SH: lanes {a[1],0} and {a[1],1};
  - SW: all 4 lanes.
- Store lane data: wd[7:0] replicated to every lane for SB; wd[15:0] replicated to both halves for SH. Unselected bytes are unchanged.
- Load extraction: pick the byte or half selected by the registered a[1:0]. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- FSM states:
  - IDLE: resp_valid=0, req_ready=1. Accept goes to RESP.
  - RESP: resp_valid=1, req_ready=resp_ready.
    - resp_ready && req_valid: accept the new request, stay in RESP.
    - resp_ready && !req_valid: go to IDLE.
    - !resp_ready: hold; rd and err stay stable.
- Memory contents are not reset and power up undefined.

## Timing
- Reset values: state IDLE, resp_valid 0, req_ready 1 (combinational from state), rd 0, err 0.
- Store: RAM written at the accept edge. Response (rd=0, err=0) is visible in the following cycle.
- Load: RAM read address registered at the accept edge. Extended data on rd in the following cycle. Latency is 1 cycle.
- Load immediately after store to the same word (back-to-back accepts): the load returns the new data. The RAM is write-first, or the unit forwards it.
- Throughput is one request per cycle while resp_ready=1.
- RAM output must not change while a response is stalled. The RAM enable is gated by accept.
- Reset asserted mid-operation:
  - any pending response is dropped immediately (resp_valid→0);
  - a store accepted on an edge before reset assertion remains written;
  - no write occurs while reset_n=0.

## Structure
- Package dm_pkg holds:
  - Funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum dm_state_e {IDLE, RESP};
  - the function computing byte enables, shifted lane data, and the misalignment flag from (Funct3, a[1:0], wd).
- Sub-module dm_bytebank: synchronous single-port RAM with 4 byte-write enables, write-first read, parameter DEPTH.
- Top-level dm_lsu contains the FSM, the request decode, the response registers (a[1:0], Funct3, err) and the extraction mux.

## Test plan
- SW a=0x010 wd=0xDEADBEEF, then LW a=0x010 → rd=0xDEADBEEF, err=0, resp_valid one cycle after accept.
- SW a=0x020 wd=0x11223344; SB a=0x021 wd=0x000000F0; LW a=0x020 → 0x1122F044. Then LB a=0x021 → 0xFFFFFFF0 and LBU a=0x021 → 0x000000F0.
- SH a=0x032 wd=0x00008001 over an existing 0; LH a=0x032 → 0xFFFF8001; LHU a=0x032 → 0x00008001; LW a=0x030 → 0x80010000.
- SH a=0x033 and LW a=0x012 → err=1, rd=0, memory unchanged (later LW reads the prior value). Funct3=011 load → err=1.
- Back-pressure: hold resp_ready=0 for 3 cycles during a load → resp_valid, rd, err stable and req_ready=0. Release → next queued request accepted in the same cycle.
- Drop reset_n while in RESP → resp_valid=0 and rd=0 asynchronously. After release, the unit returns to IDLE with req_ready=1.
